// File: rtl/seq_pattern_tx_pkg.sv
// seq_pattern_pkg
//   Shared definitions for the serial pattern transmitter:
//   - state_t     : FSM state encoding (2 bits; code 2'd3 is unused)
//   - PAT_DEFAULT : shift-register contents after reset
//   - clog2       : constant-evaluable ceiling log2 for sizing counters
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] PAT_DEFAULT = 4'b1001;

    // Returns ceil(log2(value)); clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_shift_reg.sv
// pat_shift_reg
//   PAT_W-bit parallel-load, MSB-first parallel-in/serial-out register.
//   Ports:
//     clk    in   clock, updates on posedge
//     rst    in   asynchronous active-high reset, loads PAT_DEFAULT
//     load   in   parallel load of d (has priority over shift)
//     shift  in   shift left by one, zero fill at the LSB
//     d      in   PAT_W-bit parallel load value
//     q_msb  out  current most significant bit
module pat_shift_reg #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(seq_pattern_pkg::PAT_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] d,
    output logic             q_msb
);

    logic [PAT_W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= PAT_DEFAULT;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[PAT_W-2:0], 1'b0};
        end
    end

    assign q_msb = q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Serial pattern transmitter. Captures a PAT_W-bit pattern and a repeat
//   count on an accepted start, then drives the pattern MSB-first on dout,
//   one bit per clock, reps times, with GAP zero bits between repetitions.
//
//   Handshake: start is a request sampled on posedge. It is accepted only
//   when the block is idle (busy=0) and reps is non-zero; at that edge
//   pat_in and reps are captured and busy rises. Requests while busy, or
//   with reps=0, are dropped without any side effect. Completion is a
//   one-cycle done pulse coincident with busy falling; the next request can
//   be accepted on the following edge.
//
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous active-high reset
//     start      in   transmit request
//     pat_in     in   pattern captured on accept
//     reps       in   repetition count captured on accept
//     dout       out  serial line bit (idle low), registered
//     dvalid     out  dout carries a pattern or gap bit, registered
//     busy       out  frame in progress, registered
//     done       out  one-cycle completion pulse, registered
//     state_dbg  out  current FSM state code (debug)
module seq_pattern_tx #(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter int               GAP         = 0,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(seq_pattern_pkg::PAT_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] reps,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    import seq_pattern_pkg::*;

    localparam int BIT_W = clog2(PAT_W);
    localparam int GAP_W = (clog2(GAP + 1) < 1) ? 1 : clog2(GAP + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    state_t           state, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_cnt, rep_d;
    logic [BIT_W-1:0] bit_cnt, bit_d;
    logic [GAP_W-1:0] gap_cnt, gap_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sr_load;
    logic             sr_shift;
    logic [PAT_W-1:0] sr_d;
    logic             sr_msb;

    // The shift register holds the bits still to be sent *after* the one
    // currently on the line, so its MSB is always the next dout value.
    // That lets dout stay a plain flop with no extra bit-select mux.
    pat_shift_reg #(
        .PAT_W       (PAT_W),
        .PAT_DEFAULT (PAT_DEFAULT)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (sr_d),
        .q_msb (sr_msb)
    );

    always_comb begin
        state_d  = state;
        pat_d    = pat_q;
        rep_d    = rep_cnt;
        bit_d    = bit_cnt;
        gap_d    = gap_cnt;
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_d     = {pat_q[PAT_W-2:0], 1'b0};

        case (state)
            ST_IDLE: begin
                if (start && !busy_q && (reps != '0)) begin
                    state_d  = ST_SEND;
                    pat_d    = pat_in;
                    rep_d    = reps;
                    bit_d    = BIT_LAST;
                    sr_load  = 1'b1;
                    sr_d     = {pat_in[PAT_W-2:0], 1'b0};
                    dout_d   = pat_in[PAT_W-1];
                    dvalid_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            ST_SEND: begin
                busy_d   = 1'b1;
                dvalid_d = 1'b1;
                if (bit_cnt != '0) begin
                    sr_shift = 1'b1;
                    dout_d   = sr_msb;
                    bit_d    = bit_cnt - 1'b1;
                end else begin
                    // LSB of this repetition is on the line now.
                    rep_d = (rep_cnt != '0) ? rep_cnt - 1'b1 : '0;
                    if (rep_cnt <= CNT_W'(1)) begin
                        state_d  = ST_IDLE;
                        dvalid_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LAST;
                    end else begin
                        sr_load = 1'b1;
                        dout_d  = pat_q[PAT_W-1];
                        bit_d   = BIT_LAST;
                    end
                end
            end

            ST_GAP: begin
                busy_d   = 1'b1;
                dvalid_d = 1'b1;
                if (gap_cnt != '0) begin
                    gap_d = gap_cnt - 1'b1;
                end else begin
                    state_d = ST_SEND;
                    sr_load = 1'b1;
                    dout_d  = pat_q[PAT_W-1];
                    bit_d   = BIT_LAST;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pat_q    <= PAT_DEFAULT;
            rep_cnt  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_d;
            pat_q    <= pat_d;
            rep_cnt  <= rep_d;
            bit_cnt  <= bit_d;
            gap_cnt  <= gap_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dout      = dout_q;
    assign dvalid    = dvalid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state;

endmodule
